// File: rtl/i2c_target_if.sv
// Bus between an I2C target and the logic around it.
//   scl, sda_in : bus clock and read-back SDA pad value
//   sda_oe      : target pulls SDA low when 1 (open drain)
//   rx_data/rx_valid : bytes written by the initiator
//   tx_data/tx_req   : bytes returned on a read, requested one at a time
//   busy        : target addressed, transfer in progress
interface i2c_target_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target: oversamples SCL/SDA on clk, detects START/STOP, matches a
// 7-bit address, receives write bytes and returns read bytes. SDA is only
// ever pulled low; no clock stretching.
//   clk : system clock, at least 8x the SCL rate
//   rst : asynchronous active-high reset
//   bus : i2c_target_if slave modport (all outputs registered)
module i2c_target #(
    parameter logic [6:0]  ADDR        = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    i2c_target_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] cnt, cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic       rw, rw_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data, rx_data_nxt;
    logic       rx_valid, rx_valid_nxt;
    logic       tx_req, tx_req_nxt;
    logic       busy, busy_nxt;

    // Synchronisers plus one delay stage for edge detection; reset to the idle-high bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], bus.scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_d <= scl_q[SYNC_STAGES-1];
            sda_d <= sda_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_q[SYNC_STAGES-1];
    assign sda_s     = sda_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shift    <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shift    <= shift_nxt;
            rw       <= rw_nxt;
            sda_oe   <= sda_oe_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            tx_req   <= tx_req_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and output logic; START/STOP override any edge handling
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shift_nxt    = shift;
        rw_nxt       = rw;
        sda_oe_nxt   = sda_oe;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        busy_nxt     = busy;

        if (start_det) begin
            state_nxt  = S_ADDR;
            cnt_nxt    = 3'd0;
            sda_oe_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt  = S_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            unique case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[6:0], sda_s};
                        cnt_nxt   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (shift[6:0] == ADDR) begin
                                busy_nxt  = 1'b1;
                                rw_nxt    = sda_s;
                                state_nxt = S_ADDR_ACK;
                            end else begin
                                state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK; sda_oe=1 marks that the
                // ACK bit is in progress so the second falling edge ends it.
                S_ADDR_ACK, S_WRITE_ACK: begin
                    if (scl_rise) begin
                        if (state == S_ADDR_ACK && rw && sda_oe)
                            tx_req_nxt = 1'b1;
                    end else if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else if (state == S_ADDR_ACK && rw) begin
                            shift_nxt  = bus.tx_data;
                            sda_oe_nxt = ~bus.tx_data[7];
                            cnt_nxt    = 3'd0;
                            state_nxt  = S_READ;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[6:0], sda_s};
                        cnt_nxt   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data_nxt  = {shift[6:0], sda_s};
                            rx_valid_nxt = 1'b1;
                            state_nxt    = S_WRITE_ACK;
                        end
                    end
                end
                // Bit 7 is already on the bus; count falling edges for bits 6..0, then release
                S_READ: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = 3'd0;
                            state_nxt  = S_READ_ACK;
                        end else begin
                            cnt_nxt    = cnt + 3'd1;
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                // Entered on a falling edge, so any falling edge seen here follows an ACK
                S_READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = S_IGNORE;
                        end
                    end else if (scl_fall) begin
                        shift_nxt  = bus.tx_data;
                        sda_oe_nxt = ~bus.tx_data[7];
                        cnt_nxt    = 3'd0;
                        state_nxt  = S_READ;
                    end
                end
                S_IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_req   = tx_req;
    assign bus.busy     = busy;

endmodule
